// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one AR/R read at a time, and holds the word for decode until writeback returns dnpc.
// Minimum 3 cycles from REQ to inst_valid; stalls on arready/rvalid/inst_ready/wbu_valid. Defining IFU_PERF_EN adds fetch/stall counters.
module ifu_fetch_ctrl #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [31:0]       mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  input  logic              wbu_valid,
  input  logic [ADDR_W-1:0] wbu_dnpc,
  output logic              fetch_fault
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT_R  = 3'd2,
    S_HOLD    = 3'd3,
    S_WAIT_WB = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              take_dnpc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    take_dnpc = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_REQ;
      S_REQ:    if (mem_arready) state_d = S_WAIT_R;
      S_WAIT_R: begin
        if (mem_rvalid) begin
          if (mem_rresp == 2'b00) begin
            inst_d  = mem_rdata;
            state_d = S_HOLD;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      // A same-cycle commit skips WAIT_WB entirely.
      S_HOLD: begin
        if (inst_ready) begin
          if (wbu_valid) take_dnpc = 1'b1;
          else           state_d   = S_WAIT_WB;
        end
      end
      S_WAIT_WB: if (wbu_valid) take_dnpc = 1'b1;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_FAULT;
    endcase
    // The misaligned target is still loaded into pc so it can be inspected.
    if (take_dnpc) begin
      pc_d    = wbu_dnpc;
      state_d = (wbu_dnpc[1:0] != 2'b00) ? S_FAULT : S_REQ;
    end
  end

  always_comb begin
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    inst_valid  = 1'b0;
    fetch_fault = 1'b0;
    case (state_q)
      S_REQ:    mem_arvalid = 1'b1;
      S_WAIT_R: mem_rready  = 1'b1;
      S_HOLD:   inst_valid  = 1'b1;
      S_FAULT:  fetch_fault = 1'b1;
      default:  ;
    endcase
  end

  assign mem_araddr = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == S_HOLD && inst_ready)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((state_q == S_REQ && !mem_arready) || (state_q == S_WAIT_R && !mem_rvalid))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Multi-cycle instruction-fetch controller; replaces the zero-latency combinational fetch with a handshaked memory read.
- Owns the PC register and issues read requests on an AXI-lite-style AR/R channel.
- Presents each fetched instruction to the decode stage with a valid/ready handshake.
- Waits for the writeback stage to return the next PC (dnpc) before fetching again. Single outstanding fetch, no prediction.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- ADDR_W, 32, width of PC and memory address.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_arvalid  out  1  read-address request valid.
- mem_arready  in  1  memory accepts the address.
- mem_araddr  out  ADDR_W  fetch address; always equal to pc.
- mem_rvalid  in  1  read data valid.
- mem_rready  out  1  IFU can accept read data.
- mem_rdata  in  32  instruction word.
- mem_rresp  in  2  2'b00 = OKAY; any other value = error.
- inst_valid  out  1  inst/pc valid for decode.
- inst_ready  in  1  decode accepts inst.
- inst  out  32  latched instruction.
- pc  out  ADDR_W  PC of the current instruction.
- wbu_valid  in  1  writeback commits; wbu_dnpc is valid.
- wbu_dnpc  in  ADDR_W  next PC from writeback.
- fetch_fault  out  1  sticky fault flag.

Behaviour:
- States: IDLE, REQ, WAIT_R, HOLD, WAIT_WB, FAULT. All outputs are decoded from state or from registers.
- Reset while rst=0, asynchronous and usable mid-operation:
  - state=IDLE, pc=RESET_PC, inst=0, fetch_fault=0.
  - All valid/ready outputs are 0.
  - Any in-flight request is abandoned. R beats for it that arrive after reset are ignored, because mem_rready=0 outside WAIT_R.
- IDLE: goes to REQ on the first clock after reset is released.
- REQ:
  - Drives mem_arvalid=1, mem_araddr=pc.
  - Address stays stable until mem_arvalid&&mem_arready.
  - On handshake, goes to WAIT_R.
- WAIT_R:
  - Drives mem_rready=1.
  - On mem_rvalid with mem_rresp==0: inst<=mem_rdata, go to HOLD.
  - On mem_rvalid with mem_rresp!=0: go to FAULT.
  - mem_rvalid in any other state is ignored.
  - The slave must not assert rvalid in the same cycle as the AR handshake.
- HOLD:
  - Drives inst_valid=1; inst and pc stay stable until inst_valid&&inst_ready.
  - On handshake, goes to WAIT_WB.
  - If wbu_valid is also 1 in the handshake cycle, pc<=wbu_dnpc and the state goes directly to REQ. This supports same-cycle combinational commit.
- WAIT_WB:
  - On wbu_valid, pc<=wbu_dnpc, go to REQ.
  - wbu_valid in IDLE/REQ/WAIT_R/FAULT, or in HOLD without an inst handshake, is ignored.
- Misaligned target:
  - A wbu_dnpc[1:0]!=0 captured in WAIT_WB or in the HOLD shortcut goes to FAULT.
  - pc is still updated, so the offending value is visible.
- FAULT:
  - fetch_fault=1; all valid/ready outputs are 0.
  - Terminal until reset.
- Latency:
  - Minimum 3 cycles from entering REQ to inst_valid (REQ→WAIT_R→HOLD), given arready=1 in REQ and rvalid=1 on the first WAIT_R cycle.
  - Each additional memory wait cycle adds 1.
- pc arithmetic is modulo 2^ADDR_W; wbu_dnpc is taken as-is, with no increment inside this block.

Optional Feature:
- Macro: IFU_PERF_EN.
- When defined:
  - Adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - perf_fetch_cnt increments on each inst_valid&&inst_ready.
  - perf_stall_cnt increments on every cycle in REQ with !mem_arready, or in WAIT_R with !mem_rvalid.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0013, inst_ready=1:
  - araddr=32'h8000_0000 in cycle 1.
  - inst_valid with inst=32'h0000_0013, pc=32'h8000_0000 in cycle 3.
  - wbu_valid in the same cycle with dnpc=32'h8000_0004, then next araddr=32'h8000_0004.
- Memory holds arready=0 for 4 cycles, then rvalid 2 cycles late:
  - araddr is stable throughout; inst_valid is delayed by exactly 6 cycles.
  - With IFU_PERF_EN: perf_stall_cnt=6.
- inst_ready=0 for 5 cycles: inst and pc stay constant and inst_valid stays 1; after acceptance, a wbu_valid 3 cycles later with dnpc=32'h8000_0100 gives araddr=32'h8000_0100.
- mem_rresp=2'b10 on a fetch: fetch_fault=1 and inst_valid never asserts; a later wbu_valid is ignored; after a reset pulse, fetch_fault=0 and pc=RESET_PC.
- wbu_dnpc=32'h8000_0002: fetch_fault=1, pc=32'h8000_0002, no further mem_arvalid.
- rst asserted while in WAIT_R, rvalid arrives during reset: outputs go to reset values immediately (asynchronously); the stale beat is not latched; the fetch restarts at 32'h8000_0000.
